// File: rtl/laser_pkg.sv
// Shared types and helpers for the laser tower: screen geometry, packed
// coordinate accessors and the draw-frame state encoding.
package laser_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [8:0] COLOUR_BLACK = 9'h000;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        SELECT,
        FIRE,
        DRAW,
        DONE
    } state_t;

    function automatic logic [7:0] coord_x(input logic [14:0] c);
        return c[14:7];
    endfunction

    function automatic logic [6:0] coord_y(input logic [14:0] c);
        return c[6:0];
    endfunction

    function automatic logic [14:0] pack_coord(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

    // Absolute differences are taken before the add, so the 9-bit sum never wraps.
    function automatic logic [8:0] manhattan(input logic [14:0] a, input logic [14:0] b);
        logic [7:0] dx;
        logic [6:0] dy;
        dx = (coord_x(a) >= coord_x(b)) ? coord_x(a) - coord_x(b) : coord_x(b) - coord_x(a);
        dy = (coord_y(a) >= coord_y(b)) ? coord_y(a) - coord_y(b) : coord_y(b) - coord_y(a);
        return {1'b0, dx} + {2'b00, dy};
    endfunction

endpackage

// File: rtl/laser_tower_if.sv
// Bundle between the car cluster / VGA chain (master) and the laser tower (slave).
interface laser_tower_if;

    logic        initiate;
    logic        start_laser_draw;
    logic [14:0] tower_coord;
    logic [14:0] car_0_coords;
    logic [14:0] car_1_coords;
    logic [14:0] car_2_coords;
    logic [14:0] car_3_coords;
    logic [3:0]  destroyed_cars;
    logic        laser_wren;
    logic [14:0] coord;
    logic [8:0]  colour;
    logic        laser_done_drawing;

    modport master (
        output initiate, start_laser_draw, tower_coord,
               car_0_coords, car_1_coords, car_2_coords, car_3_coords,
        input  destroyed_cars, laser_wren, coord, colour, laser_done_drawing
    );

    modport slave (
        input  initiate, start_laser_draw, tower_coord,
               car_0_coords, car_1_coords, car_2_coords, car_3_coords,
        output destroyed_cars, laser_wren, coord, colour, laser_done_drawing
    );

endinterface

// File: rtl/laser_tower_flash_drawer.sv
// Square raster drawer: one start pulse latches origin/colour, then FLASH_SIZE^2
// pixels are emitted (x fastest) through registered, screen-clipped outputs.
module flash_drawer
    import laser_pkg::*;
#(
    parameter int FLASH_SIZE = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [14:0] origin,
    input  logic [8:0]  colour_in,
    output logic        done,
    output logic        wren,
    output logic [14:0] coord,
    output logic [8:0]  colour
);

    localparam int SW = (FLASH_SIZE > 1) ? $clog2(FLASH_SIZE) : 1;
    localparam logic [SW-1:0] LAST = SW'(FLASH_SIZE - 1);

    logic          busy;
    logic [SW-1:0] col;
    logic [SW-1:0] row;
    logic [7:0]    org_x;
    logic [6:0]    org_y;
    logic [8:0]    pix_colour;
    logic [8:0]    px;
    logic [7:0]    py;
    logic          on_screen;

    assign done = busy && (col == LAST) && (row == LAST);

    always_comb begin
        px        = {1'b0, org_x} + 9'(col);
        py        = {1'b0, org_y} + 8'(row);
        on_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    end

    // Origin and colour are plain data, captured only on start.
    always_ff @(posedge clk) begin
        if (start && !busy) begin
            org_x      <= coord_x(origin);
            org_y      <= coord_y(origin);
            pix_colour <= colour_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy   <= 1'b0;
            col    <= '0;
            row    <= '0;
            wren   <= 1'b0;
            coord  <= '0;
            colour <= '0;
        end else begin
            if (start && !busy) begin
                busy <= 1'b1;
                col  <= '0;
                row  <= '0;
            end else if (busy) begin
                if (col == LAST) begin
                    col <= '0;
                    if (row == LAST) busy <= 1'b0;
                    else             row  <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // Off-screen pixels still consume a slot so frame timing never varies.
            if (busy && on_screen) begin
                wren   <= 1'b1;
                coord  <= pack_coord(px[7:0], py[6:0]);
                colour <= pix_colour;
            end else begin
                wren   <= 1'b0;
                coord  <= '0;
                colour <= '0;
            end
        end
    end

endmodule

// File: rtl/laser_tower.sv
// Laser tower: targets the first live car in range, counts hits, and draws/erases
// a flash square in the VGA daisy chain. Optional multi-hit kills: TOWER_MULTI_HIT_EN.
module laser_tower
    import laser_pkg::*;
#(
    parameter int         RANGE           = 40,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter int         FLASH_SIZE      = 4,
    parameter logic [8:0] LASER_COLOUR    = 9'h1C0
`ifdef TOWER_MULTI_HIT_EN
    ,
    parameter int         HITS_TO_KILL    = 3
`endif
) (
    input logic           clk,
    input logic           resetn,
    laser_tower_if.slave  tower
);

    state_t      state;
    logic        flash_valid;
    logic [7:0]  cooldown;
    logic [3:0]  destroyed;
    logic        done_q;
    logic [1:0]  target_idx;
    logic [14:0] target_coord;
    logic [14:0] flash_origin;
    logic [14:0] cars [4];
    logic        found;
    logic [1:0]  sel_idx;
    logic        draw_start;
    logic [14:0] draw_origin;
    logic [8:0]  draw_colour;
    logic        draw_done;
    logic        draw_wren;
    logic [14:0] draw_coord;
    logic [8:0]  draw_pix_colour;
`ifdef TOWER_MULTI_HIT_EN
    logic [2:0]  hits [4];
`endif

    assign cars[0] = tower.car_0_coords;
    assign cars[1] = tower.car_1_coords;
    assign cars[2] = tower.car_2_coords;
    assign cars[3] = tower.car_3_coords;

    // Walk downwards so the lowest qualifying index wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!destroyed[i] && (cars[i] != 15'd0) &&
                (manhattan(cars[i], tower.tower_coord) <= 9'(RANGE))) begin
                found   = 1'b1;
                sel_idx = 2'(i);
            end
        end
    end

    always_comb begin
        draw_start  = ((state == IDLE) && tower.start_laser_draw && flash_valid) || (state == FIRE);
        draw_origin = (state == FIRE) ? target_coord : flash_origin;
        draw_colour = (state == FIRE) ? LASER_COLOUR : COLOUR_BLACK;
    end

    always_ff @(posedge clk) begin
        if (state == SELECT) target_coord <= cars[sel_idx];
        if (state == FIRE)   flash_origin <= target_coord;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            flash_valid <= 1'b0;
            cooldown    <= '0;
            destroyed   <= '0;
            done_q      <= 1'b0;
            target_idx  <= '0;
`ifdef TOWER_MULTI_HIT_EN
            for (int i = 0; i < 4; i++) hits[i] <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tower.start_laser_draw) state <= flash_valid ? ERASE : SELECT;
                end
                ERASE: begin
                    if (draw_done) state <= SELECT;
                end
                SELECT: begin
                    target_idx <= sel_idx;
                    if (tower.initiate && (cooldown == 8'd0) && found) begin
                        state <= FIRE;
                    end else begin
                        if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
                        flash_valid <= 1'b0;
                        state       <= DONE;
                        done_q      <= 1'b1;
                    end
                end
                FIRE: begin
`ifdef TOWER_MULTI_HIT_EN
                    hits[target_idx] <= hits[target_idx] + 3'd1;
                    if (3'(hits[target_idx] + 3'd1) == 3'(HITS_TO_KILL))
                        destroyed[target_idx] <= 1'b1;
`else
                    destroyed[target_idx] <= 1'b1;
`endif
                    cooldown    <= 8'(COOLDOWN_FRAMES);
                    flash_valid <= 1'b1;
                    state       <= DRAW;
                end
                DRAW: begin
                    if (draw_done) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Game-state clear; the draw sequence itself is left to finish.
            if (!tower.initiate) begin
                destroyed <= '0;
                cooldown  <= '0;
`ifdef TOWER_MULTI_HIT_EN
                for (int i = 0; i < 4; i++) hits[i] <= '0;
`endif
            end
        end
    end

    flash_drawer #(
        .FLASH_SIZE (FLASH_SIZE)
    ) u_flash_drawer (
        .clk       (clk),
        .resetn    (resetn),
        .start     (draw_start),
        .origin    (draw_origin),
        .colour_in (draw_colour),
        .done      (draw_done),
        .wren      (draw_wren),
        .coord     (draw_coord),
        .colour    (draw_pix_colour)
    );

    assign tower.destroyed_cars     = destroyed;
    assign tower.laser_done_drawing = done_q;
    assign tower.laser_wren         = draw_wren;
    assign tower.coord              = draw_coord;
    assign tower.colour             = draw_pix_colour;

endmodule

// File: tb/tb_laser_tower.sv
// Directed bench for laser_tower (COOLDOWN_FRAMES=2), expectations adapt to TOWER_MULTI_HIT_EN.
module tb_laser_tower;

    localparam logic [8:0] LASER = 9'h1C0;

    logic clk;
    logic resetn;

    laser_tower_if tif ();

    laser_tower #(
        .COOLDOWN_FRAMES (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .tower  (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed;
    int          total;
    int          nw;
    int          nfire;
    int          lat;
    int          sum;
    logic [14:0] wcoord [64];
    logic [8:0]  wcol [64];

    function automatic logic [14:0] pk(input int x, input int y);
        logic [7:0] xs;
        logic [6:0] ys;
        xs = 8'(x);
        ys = 7'(y);
        return {xs, ys};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic set_cars(input logic [14:0] c0, input logic [14:0] c1,
                            input logic [14:0] c2, input logic [14:0] c3);
        tif.car_0_coords = c0;
        tif.car_1_coords = c1;
        tif.car_2_coords = c2;
        tif.car_3_coords = c3;
    endtask

    // One draw frame: pulse start, log writes, return cycles until done (-1 on timeout).
    task automatic frame(input int drop_at, output int latency);
        tick();
        nw    = 0;
        nfire = 0;
        tif.start_laser_draw = 1'b1;
        tick();
        tif.start_laser_draw = 1'b0;
        latency = -1;
        for (int k = 1; k <= 100; k++) begin
            if (tif.laser_wren) begin
                if (nw < 64) begin
                    wcoord[nw] = tif.coord;
                    wcol[nw]   = tif.colour;
                end
                nw++;
                if (tif.colour == LASER) nfire++;
            end
            tif.initiate = (k == drop_at) ? 1'b0 : 1'b1;
            if (tif.laser_done_drawing) begin
                latency = k;
                break;
            end
            tick();
        end
        tif.initiate = 1'b1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        resetn = 1'b0;
        tif.initiate = 1'b1;
        tif.start_laser_draw = 1'b0;
        tif.tower_coord = pk(80, 60);
        set_cars('0, '0, '0, '0);
        tick();
        tick();
        check("rst_wren", 32'(tif.laser_wren), 32'd0);
        check("rst_coord", 32'(tif.coord), 32'd0);
        check("rst_colour", 32'(tif.colour), 32'd0);
        check("rst_done", 32'(tif.laser_done_drawing), 32'd0);
        check("rst_destroyed", 32'(tif.destroyed_cars), 32'd0);
        resetn = 1'b1;
        tick();

        // Reset in the middle of a DRAW.
        set_cars(pk(90, 70), '0, '0, '0);
        tif.start_laser_draw = 1'b1;
        tick();
        tif.start_laser_draw = 1'b0;
        repeat (5) tick();
        check("middraw_wren", 32'(tif.laser_wren), 32'd1);
        #2 resetn = 1'b0;
        tick();
        check("midrst_wren", 32'(tif.laser_wren), 32'd0);
        check("midrst_coord", 32'(tif.coord), 32'd0);
        check("midrst_colour", 32'(tif.colour), 32'd0);
        check("midrst_done", 32'(tif.laser_done_drawing), 32'd0);
        check("midrst_destroyed", 32'(tif.destroyed_cars), 32'd0);
        resetn = 1'b1;
        set_cars('0, '0, '0, '0);
        frame(0, lat);
        check("postrst_lat", 32'(lat), 32'd2);
        check("postrst_writes", 32'(nw), 32'd0);

        // Basic fire at car0 (90,70), distance 20.
        do_reset();
        tif.tower_coord = pk(80, 60);
        set_cars(pk(90, 70), '0, '0, '0);
        frame(0, lat);
        check("fire_lat", 32'(lat), 32'd19);
        check("fire_writes", 32'(nw), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fire_px%0d", i), 32'(wcoord[i]), 32'(pk(90 + i % 4, 70 + i / 4)));
            check($sformatf("fire_col%0d", i), 32'(wcol[i]), 32'(LASER));
        end
`ifdef TOWER_MULTI_HIT_EN
        check("fire_destroyed", 32'(tif.destroyed_cars), 32'h0);
`else
        check("fire_destroyed", 32'(tif.destroyed_cars), 32'h1);
`endif

        // Cooldown of 2 frames with targets staying in range.
        do_reset();
        set_cars(pk(90, 70), pk(85, 60), pk(70, 55), '0);
        frame(0, lat);
        check("cd_f1_lat", 32'(lat), 32'd19);
        check("cd_f1_fire", 32'(nfire), 32'd16);
        check("cd_f1_org", 32'(wcoord[0]), 32'(pk(90, 70)));
        frame(0, lat);
        check("cd_f2_lat", 32'(lat), 32'd18);
        check("cd_f2_writes", 32'(nw), 32'd16);
        check("cd_f2_fire", 32'(nfire), 32'd0);
        check("cd_f2_col", 32'(wcol[15]), 32'd0);
        check("cd_f2_org", 32'(wcoord[0]), 32'(pk(90, 70)));
        frame(0, lat);
        check("cd_f3_lat", 32'(lat), 32'd2);
        check("cd_f3_writes", 32'(nw), 32'd0);
        frame(0, lat);
        check("cd_f4_lat", 32'(lat), 32'd19);
        check("cd_f4_fire", 32'(nfire), 32'd16);
`ifdef TOWER_MULTI_HIT_EN
        check("cd_f4_org", 32'(wcoord[0]), 32'(pk(90, 70)));
`else
        check("cd_f4_org", 32'(wcoord[0]), 32'(pk(85, 60)));
`endif

        // Car0 out of range (distance 70), car1 at distance 5.
        do_reset();
        set_cars(pk(150, 60), pk(85, 60), '0, '0);
        frame(0, lat);
        check("tgt_org", 32'(wcoord[0]), 32'(pk(85, 60)));
        sum = nfire;
        for (int f = 2; f <= 7; f++) begin
            frame(0, lat);
            sum += nfire;
            if (f == 4) begin
`ifdef TOWER_MULTI_HIT_EN
                check("tgt_f4_destroyed", 32'(tif.destroyed_cars), 32'h0);
`else
                check("tgt_f4_destroyed", 32'(tif.destroyed_cars), 32'h2);
`endif
            end
        end
`ifdef TOWER_MULTI_HIT_EN
        check("tgt_fire_total", 32'(sum), 32'd48);
`else
        check("tgt_fire_total", 32'(sum), 32'd16);
`endif
        check("tgt_destroyed", 32'(tif.destroyed_cars), 32'h2);
        sum = 0;
        for (int f = 8; f <= 11; f++) begin
            frame(0, lat);
            sum += nfire;
        end
        check("tgt_no_refire", 32'(sum), 32'd0);
        check("tgt_sticky", 32'(tif.destroyed_cars), 32'h2);

        // Flash at the bottom-right corner is clipped to 2x2.
        do_reset();
        tif.tower_coord = pk(150, 110);
        set_cars(pk(158, 118), '0, '0, '0);
        frame(0, lat);
        check("clip_lat", 32'(lat), 32'd19);
        check("clip_writes", 32'(nw), 32'd4);
        check("clip_px0", 32'(wcoord[0]), 32'(pk(158, 118)));
        check("clip_px1", 32'(wcoord[1]), 32'(pk(159, 118)));
        check("clip_px2", 32'(wcoord[2]), 32'(pk(158, 119)));
        check("clip_px3", 32'(wcoord[3]), 32'(pk(159, 119)));

        // initiate low for one cycle during DRAW.
        do_reset();
        tif.tower_coord = pk(80, 60);
        set_cars(pk(90, 70), '0, '0, '0);
        frame(10, lat);
        check("init_lat", 32'(lat), 32'd19);
        check("init_writes", 32'(nw), 32'd16);
        check("init_destroyed", 32'(tif.destroyed_cars), 32'h0);
        frame(0, lat);
        check("init_f2_lat", 32'(lat), 32'd35);
`ifdef TOWER_MULTI_HIT_EN
        for (int f = 3; f <= 5; f++) frame(0, lat);
        check("init_f5_destroyed", 32'(tif.destroyed_cars), 32'h0);
        for (int f = 6; f <= 8; f++) frame(0, lat);
        check("init_f8_destroyed", 32'(tif.destroyed_cars), 32'h1);
`else
        check("init_f2_destroyed", 32'(tif.destroyed_cars), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/laser_tower.md
Name: laser_tower

Overview:
- Consumer end of the car interface. Reads the four packed car locations, chooses the first live car in range, and counts hits against it.
- Publishes destroyed_cars back to the car cluster.
- Sits in the VGA draw daisy chain directly after the car cluster. It is started by the car cluster's done-drawing pulse, draws and erases a laser flash, then pulses its own done signal.
- Coordinate format: coord[14:7] = x (0..159), coord[6:0] = y (0..119). Colour is 9-bit RGB333.

Parameters:
- RANGE, 40: max Manhattan distance (pixels) from tower to car for targeting.
- HITS_TO_KILL, 3: hits needed to destroy a car (1..7).
- COOLDOWN_FRAMES, 8: draw frames between shots (0..255).
- FLASH_SIZE, 4: flash square edge in pixels (power of 2, at most 8).
- LASER_COLOUR, 9'h1C0: flash colour.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- initiate  in  1  any stage in progress; low clears stage state
- start_laser_draw  in  1  one-cycle pulse from car cluster done-drawing
- tower_coord  in  15  packed tower position
- car_0_coords / car_1_coords / car_2_coords / car_3_coords  in  15 each  packed car positions
- destroyed_cars  out  4  sticky per-car destroyed flags, registered
- laser_wren  out  1  VGA write enable
- coord  out  15  VGA pixel coordinate
- colour  out  9  VGA pixel colour
- laser_done_drawing  out  1  one-cycle pulse at end of draw frame

Behaviour:
- Reset (resetn low, any time): state IDLE. destroyed_cars, hit counters, cooldown, flash_valid, laser_wren, coord, colour and laser_done_drawing all become 0.
- initiate low: destroyed_cars, hit counters and cooldown cleared synchronously. A draw sequence already in progress still completes and still pulses done, so the chain never stalls.
- FSM states:
  - IDLE: waits for start_laser_draw; other inputs ignored.
  - On start: go to ERASE if flash_valid, else SELECT.
  - ERASE: FLASH_SIZE² cycles writing colour 0 over the stored previous flash origin, then SELECT.
  - SELECT: 1 cycle. target = lowest index i with all of: destroyed_cars[i]=0, car_i_coords≠0 (0 = not spawned), |dx|+|dy| ≤ RANGE (9-bit unsigned math, no wrap).
    - If initiate=1, cooldown=0 and a target exists: go to FIRE.
    - Else: if cooldown>0, decrement it; clear flash_valid; go to DONE.
  - FIRE: 1 cycle. Increment the target's hit counter. When it reaches HITS_TO_KILL, set destroyed_cars[target]; the bit is visible the next cycle. Load cooldown = COOLDOWN_FRAMES; latch flash origin = target coords; set flash_valid. Go to DRAW.
  - DRAW: FLASH_SIZE² cycles writing LASER_COLOUR, raster order x fastest, then DONE.
  - DONE: laser_done_drawing=1 for exactly one cycle, then IDLE.
- Pixel output is registered: laser_wren/coord/colour lag the pixel counter by 1 cycle. The last pixel write appears in the DONE cycle.
- Clipping: a pixel with x>159 or y>119 gets laser_wren=0; the counter still advances, so timing is fixed.
- start_laser_draw outside IDLE is ignored.
- Frame latency, start pulse to done pulse, measured from the first cycle after the pulse:
  - no erase, no fire: 2 cycles
  - erase only: FLASH_SIZE²+2
  - fire, no erase: FLASH_SIZE²+3
  - erase and fire: 2·FLASH_SIZE²+3
- Outputs when not writing: laser_wren=0, coord=0, colour=0.

Optional Feature:
- Macro TOWER_MULTI_HIT_EN.
- Defined: hit counters (3-bit per car) and HITS_TO_KILL as above.
- Undefined: no hit counters; FIRE sets destroyed_cars[target] immediately and HITS_TO_KILL is ignored.

Decomposition:
- Package laser_pkg: SCREEN_W=160, SCREEN_H=120, coord pack/unpack functions, COLOUR_BLACK, state enum (IDLE, ERASE, SELECT, FIRE, DRAW, DONE).
- Sub-module flash_drawer: start/done counter-based square drawer. Inputs origin and colour; outputs registered wren/coord/colour with clipping. Used for both ERASE and DRAW.

Test Plan:
- Reset mid-DRAW → all outputs 0 next edge; the following start pulse gives done after 2 cycles with no writes.
- Tower (80,60), car0 (90,70) at distance 20, cooldown 0, start pulse → 16 writes of 9'h1C0 at x 90..93, y 70..73, raster order; done pulse 19 cycles after start.
- Car0 (150,60), car1 (85,60), car0 out of range → car1 targeted; after 3 fired frames destroyed_cars=4'b0010. Bit stays set, and car1 is never targeted again.
- COOLDOWN_FRAMES=2, target stays in range → fire on frames 1 and 4 only; frame 2 erases (16 black writes), frame 3 has no writes.
- Flash origin (158,118) → only 4 writes, pixels (158..159, 118..119); done timing unchanged.
- initiate low for one cycle during DRAW → draw completes, done pulses, destroyed_cars and hits read 0 afterwards; compiled without TOWER_MULTI_HIT_EN, a single FIRE sets the bit.
